serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one instance of the existing `fulladder` cell.
- The `fulladder` port order is (cout, s, x, y, cin).
- The block sits directly upstream of the `fulladder` and feeds it one operand bit pair plus a registered carry per clock, LSB first.
- It collects the sum bits into a result register and presents the full sum and carry-out with a one-cycle done pulse.
- Purpose: area-minimal adder for the lab datapath; also the first clocked exercise of the full-adder cell.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2 to 32.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk edge while idle
- a  input  WIDTH  operand A; sampled only on the accepted start edge
- b  input  WIDTH  operand B; sampled only on the accepted start edge
- cin  input  1  carry-in; sampled only on the accepted start edge
- busy  output  1  high while a serial addition is in progress
- done  output  1  one-cycle pulse; sum/cout valid from this cycle on
- sum  output  WIDTH  registered result a+b+cin, bits WIDTH-1:0
- cout  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n low asynchronously forces state=IDLE, busy=0, done=0, sum=0, cout=0, and clears the operand shift registers, result shift register, carry flop and bit counter.
- Internal state: a_sr and b_sr (WIDTH bits each), res_sr (WIDTH bits), carry flop, bit counter of $clog2(WIDTH) bits.
- FSM has two states, IDLE and SHIFT. busy is the registered indication of state==SHIFT.
- IDLE:
  - start=1 at edge E0 loads a_sr<=a, b_sr<=b, carry<=cin, count<=0, state<=SHIFT.
  - busy=1 after E0.
  - start=0 keeps IDLE; outputs hold.
- SHIFT, each edge:
  - The `fulladder` computes x=a_sr[0], y=b_sr[0], cin=carry.
  - res_sr <= {fa_s, res_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right with zero fill.
  - carry <= fa_cout.
  - count <= count+1.
- Completion, on the edge where count==WIDTH-1 (edge E_WIDTH):
  - sum <= {fa_s, res_sr[WIDTH-1:1]}, cout <= fa_cout, done <= 1.
  - state <= IDLE, busy <= 0.
- Latency: result visible WIDTH cycles after the start edge; done is high for exactly the cycle following E_WIDTH.
- done clears on the next edge unless a new completion occurs on that edge (impossible for WIDTH>=2).
- sum and cout hold the last result until the next completion or reset. They do not change during SHIFT.
- start during SHIFT is ignored, and the operands in flight are unaffected.
- start high in the done cycle (state IDLE) is accepted: back-to-back throughput is one addition per WIDTH+1 cycles.
- a, b and cin changing after the start edge have no effect.
- Reset mid-SHIFT aborts the addition: outputs go to 0 immediately, with no done pulse. The next start after rst_n release operates normally.
- Arithmetic is unsigned. {cout,sum} == a+b+cin modulo 2^(WIDTH+1), i.e. exact.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> busy=0, done=0, sum=0, cout=0 before the next clk edge.
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulsed once:
  - busy high 8 cycles, then done=1 one cycle with sum=8'h10, cout=0.
  - sum unchanged after done until next op.
- Carry extremes:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
  - a=0, b=0, cin=1 -> sum=8'h01, cout=0.
- Ignored inputs:
  - start held high for all of an operation.
  - a and b changed to 8'hAA/8'h55 during busy.
  - -> first result (8'h0F+8'h01 = 8'h10) reported; second op begins only in the done cycle.
- Abort: rst_n pulsed low during busy cycle 4 -> no done, outputs 0; next op a=8'h12, b=8'h34 -> sum=8'h46, cout=0.
- Exhaustive: WIDTH=3, all 128 (a,b,cin) combos issued back-to-back -> each {cout,sum} equals a+b+cin, done every 4 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// fulladder
//   One-bit full adder cell used by the bit-serial adder below.
//   Ports:
//     cout - carry out (majority of x, y, cin)
//     s    - sum bit (x ^ y ^ cin)
//     x    - operand bit
//     y    - operand bit
//     cin  - carry in
// ---------------------------------------------------------------------------
module fulladder (
    output logic cout,
    output logic s,
    input  logic x,
    input  logic y,
    input  logic cin
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit unsigned adder built around a single fulladder.
//   One operand bit pair is added per clock, LSB first, with the carry held
//   in a flop between cycles. The complete result is published with a
//   one-cycle done pulse WIDTH cycles after the accepted start edge.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     start - request, accepted only while idle
//     a, b  - WIDTH-bit operands, captured on the accepted start edge
//     cin   - carry in, captured on the accepted start edge
//     busy  - high while an addition is being shifted through
//     done  - one-cycle pulse; sum/cout valid from this cycle on
//     sum   - registered result a+b+cin, bits WIDTH-1:0
//     cout  - registered carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    count;

    logic fa_s;
    logic fa_cout;

    // The cell always sees the current LSBs; its outputs are only used
    // while shifting.
    fulladder u_fa (
        .cout (fa_cout),
        .s    (fa_s),
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry)
    );

    // Sequencer: load operands on an accepted start, then shift one bit per
    // clock. The final sum bit comes straight from the cell on the last edge
    // so the published sum does not wait an extra cycle for res_sr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        count <= '0;
                        state <= SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        sum   <= {fa_s, res_sr[WIDTH-1:1]};
                        cout  <= fa_cout;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder. Two instances are used: an 8-bit one
//   for the directed and random cases and a 3-bit one for the exhaustive
//   back-to-back sweep. Expected results are computed as plain a+b+cin and
//   queued at the accepted start edge; monitors pop them when done pulses.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start3;
    logic [2:0] a3;
    logic [2:0] b3;
    logic       cin3;
    logic       busy3;
    logic       done3;
    logic [2:0] sum3;
    logic       cout3;

    int checks;
    int failures;

    logic [8:0] q8[$];
    logic [3:0] q3[$];
    logic [8:0] hold8;
    logic [3:0] hold3;
    int         busyCnt8;
    int         busyCnt3;
    int         cycle;
    int         lastDone3;
    bit         done3Seen;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .cin   (cin3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [32:0] actual,
                               input logic [32:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // 8-bit monitor: checks every result against the queue, the busy
    // duration, and that outputs hold between completions.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold8    = '0;
            busyCnt8 = 0;
        end else begin
            if (busy8) busyCnt8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    checkOutput("spurious_done8", 33'(done8), 33'd0);
                end else begin
                    hold8 = q8.pop_front();
                    checkOutput("result8", 33'({cout8, sum8}), 33'(hold8));
                    checkOutput("busy_len8", 33'(busyCnt8), 33'd8);
                    checkOutput("busy_in_done8", 33'(busy8), 33'd0);
                end
                busyCnt8 = 0;
            end else begin
                checkOutput("hold8", 33'({cout8, sum8}), 33'(hold8));
            end
        end
    end

    // 3-bit monitor: same checks plus done spacing during the sweep.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold3     = '0;
            busyCnt3  = 0;
            done3Seen = 1'b0;
        end else begin
            if (busy3) busyCnt3++;
            if (done3) begin
                if (q3.size() == 0) begin
                    checkOutput("spurious_done3", 33'(done3), 33'd0);
                end else begin
                    hold3 = q3.pop_front();
                    checkOutput("result3", 33'({cout3, sum3}), 33'(hold3));
                    checkOutput("busy_len3", 33'(busyCnt3), 33'd3);
                end
                if (done3Seen)
                    checkOutput("done_spacing3", 33'(cycle - lastDone3), 33'd4);
                done3Seen = 1'b1;
                lastDone3 = cycle;
                busyCnt3  = 0;
            end else begin
                checkOutput("hold3", 33'({cout3, sum3}), 33'(hold3));
            end
        end
    end

    // Waits (bounded) until the 8-bit instance is idle.
    task automatic waitIdle8();
        int n;
        n = 0;
        while (busy8 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy8) checkOutput("idle_timeout8", 33'(busy8), 33'd0);
    endtask

    // Issues one 8-bit addition and queues its exact result.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv);
        waitIdle8();
        a8     = av;
        b8     = bv;
        cin8   = cv;
        start8 = 1'b1;
        @(posedge clk);
        q8.push_back(9'(av) + 9'(bv) + 9'(cv));
        #1;
        start8 = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((q8.size() != 0 || q3.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue8_empty", 33'(q8.size()), 33'd0);
        checkOutput("queue3_empty", 33'(q3.size()), 33'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cycle    = 0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        start3 = 0; a3 = 0; b3 = 0; cin3 = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_busy", 33'(busy8), 33'd0);
        checkOutput("reset_done", 33'(done8), 33'd0);
        checkOutput("reset_result", 33'({cout8, sum8}), 33'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic and carry cases");
        applyStimulus(8'h0F, 8'h01, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b1);
        waitIdle8();
        repeat (3) @(posedge clk);

        $display("[TB] asynchronous reset while idle");
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", 33'(busy8), 33'd0);
        checkOutput("async_reset_done", 33'(done8), 33'd0);
        checkOutput("async_reset_result", 33'({cout8, sum8}), 33'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] start held, operands changed during busy");
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        waitIdle8();
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        q8.push_back(9'h010);
        #1;
        a8 = 8'hAA; b8 = 8'h55;
        repeat (9) @(posedge clk);
        q8.push_back(9'h0FF);
        #1;
        start8 = 1'b0;
        waitIdle8();

        $display("[TB] abort during busy");
        applyStimulus(8'h33, 8'h11, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(q8.pop_back());
        #1;
        checkOutput("abort_busy", 33'(busy8), 33'd0);
        checkOutput("abort_result", 33'({cout8, sum8}), 33'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(8'h12, 8'h34, 1'b0);

        $display("[TB] random operands");
        for (int i = 0; i < 20; i++)
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
        waitIdle8();

        $display("[TB] exhaustive 3-bit back-to-back");
        start3 = 1'b1;
        for (int k = 0; k < 128; k++) begin
            a3   = 3'(k >> 4);
            b3   = 3'(k >> 1);
            cin3 = 1'(k);
            if (k == 0) @(posedge clk);
            else repeat (4) @(posedge clk);
            q3.push_back(4'(a3) + 4'(b3) + 4'(cin3));
            #1;
        end
        start3 = 1'b0;

        waitDrain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, failures);
        $finish;
    end

endmodule
